// File: rtl/common_pkg.sv
// Shared bus widths, CRTC register defaults and Wishbone address helpers.
package common_pkg;

    localparam int unsigned DATA_WIDTH    = 8;
    localparam int unsigned WB_ADDR_WIDTH = 16;
    localparam int unsigned NUM_CRTC_REGS = 14;

    localparam logic [WB_ADDR_WIDTH-1:0] CRTC_WB_BASE = 16'h0400;

    // Power-on values for R0..R13 (standard 40-column text timing).
    localparam logic [7:0] CRTC_DEFAULTS [NUM_CRTC_REGS] = '{
        8'd49, 8'd40, 8'd41, 8'd15, 8'd39, 8'd0, 8'd25,
        8'd32, 8'd0,  8'd9,  8'd0,  8'd0,  8'd16, 8'd0
    };

    function automatic logic [WB_ADDR_WIDTH-1:0] wb_crtc_addr(input int unsigned idx);
        return CRTC_WB_BASE | WB_ADDR_WIDTH'(idx & 32'h1f);
    endfunction

    function automatic logic [7:0] crtc_default(input int unsigned idx);
        if (idx < NUM_CRTC_REGS) begin
            return CRTC_DEFAULTS[idx];
        end
        return 8'h00;
    endfunction

endpackage

// File: rtl/crtc_wb_regs.sv
// CRTC register file shared between a pipelined Wishbone port and the
// 6845-style CPU address/data register interface.
module crtc_wb_regs
    import common_pkg::*;
#(
    parameter int unsigned NUM_REGS = 18
) (
    input  logic                          wb_clock_i,
    input  logic                          reset_i,
    input  logic [WB_ADDR_WIDTH-1:0]      wb_addr_i,
    input  logic [DATA_WIDTH-1:0]         wb_data_i,
    output logic [DATA_WIDTH-1:0]         wb_data_o,
    input  logic                          wb_we_i,
    input  logic                          wb_cycle_i,
    input  logic                          wb_strobe_i,
    output logic                          wb_stall_o,
    output logic                          wb_ack_o,
    input  logic                          crtc_clk_en_i,
    input  logic                          crtc_cs_i,
    input  logic                          crtc_we_i,
    input  logic                          crtc_rs_i,
    input  logic [7:0]                    crtc_data_i,
    output logic [7:0]                    crtc_data_o,
    output logic                          crtc_data_oe,
    output logic [NUM_REGS-1:0][7:0]      crtc_regs_o
);

    logic [NUM_REGS-1:0][7:0] regs;
    logic [4:0]               addr_q;
    logic                     ack_q;
    logic [4:0]               wb_idx;
    logic                     cpu_event;
    logic                     cpu_addr_wr;
    logic                     cpu_data_wr;
    logic                     wb_accept;
    logic [7:0]               wb_rd_val;
    logic [7:0]               cpu_rd_val;
    logic                     unused_addr_bits;

    assign wb_idx           = wb_addr_i[4:0];
    assign unused_addr_bits = ^wb_addr_i[WB_ADDR_WIDTH-1:5];

    assign cpu_event   = crtc_clk_en_i && crtc_cs_i;
    assign cpu_addr_wr = cpu_event && crtc_we_i && !crtc_rs_i;
    assign cpu_data_wr = cpu_event && crtc_we_i && crtc_rs_i;

    // A CPU data write owns the register file this cycle; Wishbone retries.
    assign wb_stall_o = cpu_data_wr;
    assign wb_accept  = wb_cycle_i && wb_strobe_i && !wb_stall_o;

    // Read muxes; indices beyond the implemented range read as zero.
    always_comb begin
        wb_rd_val  = 8'h00;
        cpu_rd_val = 8'h00;
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
            if (wb_idx == 5'(i)) begin
                wb_rd_val = regs[i];
            end
            if (addr_q == 5'(i)) begin
                cpu_rd_val = regs[i];
            end
        end
    end

    assign crtc_data_oe = crtc_cs_i && !crtc_we_i && crtc_rs_i;
    assign crtc_data_o  = cpu_rd_val;
    assign crtc_regs_o  = regs;

    // Register file: CPU write takes priority over a Wishbone write.
    always_ff @(posedge wb_clock_i or posedge reset_i) begin
        if (reset_i) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                regs[i] <= crtc_default(i);
            end
        end else begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                if (cpu_data_wr && addr_q == 5'(i)) begin
                    regs[i] <= crtc_data_i;
                end else if (wb_accept && wb_we_i && wb_idx == 5'(i)) begin
                    regs[i] <= 8'(wb_data_i);
                end
            end
        end
    end

    always_ff @(posedge wb_clock_i or posedge reset_i) begin
        if (reset_i) begin
            addr_q <= 5'd0;
        end else if (cpu_addr_wr) begin
            addr_q <= crtc_data_i[4:0];
        end
    end

    // Single-stage ack / read-data pipeline.
    always_ff @(posedge wb_clock_i or posedge reset_i) begin
        if (reset_i) begin
            ack_q     <= 1'b0;
            wb_data_o <= '0;
        end else begin
            ack_q <= wb_accept;
            if (wb_accept) begin
                wb_data_o <= wb_we_i ? '0 : DATA_WIDTH'(wb_rd_val);
            end
        end
    end

    // An ack is dropped if the initiator has abandoned the cycle.
    assign wb_ack_o = ack_q && wb_cycle_i;

endmodule

// File: tb/tb_crtc_wb_regs.sv
// Randomized and directed checks of crtc_wb_regs against a behavioural model.
module tb_crtc_wb_regs;
    import common_pkg::*;

    localparam int unsigned NREGS = 18;

    logic                      wb_clock_i = 1'b0;
    logic                      reset_i    = 1'b1;
    logic [WB_ADDR_WIDTH-1:0]  wb_addr_i  = '0;
    logic [DATA_WIDTH-1:0]     wb_data_i  = '0;
    logic [DATA_WIDTH-1:0]     wb_data_o;
    logic                      wb_we_i     = 1'b0;
    logic                      wb_cycle_i  = 1'b0;
    logic                      wb_strobe_i = 1'b0;
    logic                      wb_stall_o;
    logic                      wb_ack_o;
    logic                      crtc_clk_en_i = 1'b0;
    logic                      crtc_cs_i     = 1'b0;
    logic                      crtc_we_i     = 1'b0;
    logic                      crtc_rs_i     = 1'b0;
    logic [7:0]                crtc_data_i   = 8'h00;
    logic [7:0]                crtc_data_o;
    logic                      crtc_data_oe;
    logic [NREGS-1:0][7:0]     crtc_regs_o;

    crtc_wb_regs #(.NUM_REGS(NREGS)) dut (
        .wb_clock_i   (wb_clock_i),
        .reset_i      (reset_i),
        .wb_addr_i    (wb_addr_i),
        .wb_data_i    (wb_data_i),
        .wb_data_o    (wb_data_o),
        .wb_we_i      (wb_we_i),
        .wb_cycle_i   (wb_cycle_i),
        .wb_strobe_i  (wb_strobe_i),
        .wb_stall_o   (wb_stall_o),
        .wb_ack_o     (wb_ack_o),
        .crtc_clk_en_i(crtc_clk_en_i),
        .crtc_cs_i    (crtc_cs_i),
        .crtc_we_i    (crtc_we_i),
        .crtc_rs_i    (crtc_rs_i),
        .crtc_data_i  (crtc_data_i),
        .crtc_data_o  (crtc_data_o),
        .crtc_data_oe (crtc_data_oe),
        .crtc_regs_o  (crtc_regs_o)
    );

    always #5 wb_clock_i = ~wb_clock_i;

    int n_vec = 0;
    int n_err = 0;

    // Reference state: register contents, CPU address latch, pending ack.
    int unsigned mregs [NREGS];
    int unsigned maddr;
    bit          pend;
    bit          pend_we;
    int unsigned pend_data;

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int unsigned model_rd(input int unsigned idx);
        return (idx < NREGS) ? mregs[idx] : 0;
    endfunction

    function automatic logic [NREGS*8-1:0] model_vec();
        logic [NREGS*8-1:0] v;
        for (int i = 0; i < NREGS; i++) v[i*8 +: 8] = 8'(mregs[i]);
        return v;
    endfunction

    task automatic model_reset();
        int unsigned dflt [14] = '{49, 40, 41, 15, 39, 0, 25, 32, 0, 9, 0, 0, 16, 0};
        for (int i = 0; i < NREGS; i++) mregs[i] = (i < 14) ? dflt[i] : 0;
        maddr = 0;
        pend  = 0;
    endtask

    // One bus cycle: drive, check combinational and pipelined outputs, advance model.
    task automatic cycle(input bit cyc, input bit stb, input bit we, input int unsigned idx,
                         input logic [7:0] wd, input bit cen, input bit cs, input bit cwe,
                         input bit crs, input logic [7:0] cd);
        bit exp_stall;
        bit accept;
        wb_cycle_i    = cyc;
        wb_strobe_i   = stb;
        wb_we_i       = we;
        wb_addr_i     = wb_crtc_addr(idx);
        wb_data_i     = wd;
        crtc_clk_en_i = cen;
        crtc_cs_i     = cs;
        crtc_we_i     = cwe;
        crtc_rs_i     = crs;
        crtc_data_i   = cd;
        #1;
        check("ack", wb_ack_o, pend && cyc);
        if (pend && cyc && !pend_we) check("rdata", wb_data_o, pend_data);
        exp_stall = cen && cs && cwe && crs;
        check("stall", wb_stall_o, exp_stall);
        check("oe", crtc_data_oe, cs && !cwe && crs);
        check("cdata", crtc_data_o, model_rd(maddr));
        check("regs", crtc_regs_o, model_vec());
        accept = cyc && stb && !exp_stall;
        pend   = accept;
        if (accept) begin
            pend_we   = we;
            pend_data = we ? 0 : model_rd(idx);
            if (we && idx < NREGS) mregs[idx] = wd;
        end
        if (cen && cs && cwe) begin
            if (!crs) maddr = cd & 32'h1f;
            else if (maddr < NREGS) mregs[maddr] = cd;
        end
        @(posedge wb_clock_i);
        #1;
    endtask

    task automatic idle();
        cycle(0, 0, 0, 0, 8'h00, 0, 0, 0, 0, 8'h00);
    endtask

    task automatic wb_rd(input int unsigned idx);
        cycle(1, 1, 0, idx, 8'h00, 0, 0, 0, 0, 8'h00);
    endtask

    task automatic wb_wr(input int unsigned idx, input logic [7:0] d);
        cycle(1, 1, 1, idx, d, 0, 0, 0, 0, 8'h00);
    endtask

    initial begin
        model_reset();
        reset_i = 1'b1;
        repeat (3) @(posedge wb_clock_i);
        #1;
        check("rst_ack", wb_ack_o, 1'b0);
        check("rst_data", wb_data_o, 8'h00);
        check("rst_regs", crtc_regs_o, model_vec());
        reset_i = 1'b0;
        idle();

        // Defaults read back through Wishbone, back to back.
        for (int unsigned i = 0; i < 14; i++) wb_rd(i);
        idle();

        // Wishbone write then read of R1.
        wb_wr(1, 8'h50);
        wb_rd(1);
        idle();
        check("r1_after_wb", crtc_regs_o[1], 8'h50);

        // CPU write collides with Wishbone write to R1; retry afterwards.
        cycle(0, 0, 0, 0, 8'h00, 1, 1, 1, 0, 8'h01);
        cycle(1, 1, 1, 1, 8'h77, 1, 1, 1, 1, 8'h28);
        check("r1_cpu_wins", crtc_regs_o[1], 8'h28);
        wb_wr(1, 8'h77);
        idle();
        check("r1_retry", crtc_regs_o[1], 8'h77);

        // CPU read of the data register.
        cycle(0, 0, 0, 0, 8'h00, 1, 1, 0, 1, 8'h00);

        // Out-of-range index.
        wb_rd(20);
        wb_wr(20, 8'hA5);
        idle();

        // Back-to-back reads of R9 and R12.
        wb_rd(9);
        wb_rd(12);
        idle();

        // Ack suppressed when the cycle is dropped.
        wb_rd(3);
        idle();

        // Reset the cycle after acceptance: no ack, defaults restored.
        wb_rd(1);
        reset_i = 1'b1;
        #1;
        check("midrst_ack", wb_ack_o, 1'b0);
        check("midrst_data", wb_data_o, 8'h00);
        @(posedge wb_clock_i);
        #1;
        reset_i = 1'b0;
        model_reset();
        wb_cycle_i = 1'b1;
        #1;
        check("postrst_ack", wb_ack_o, 1'b0);
        idle();
        wb_rd(1);
        idle();
        check("r1_default", crtc_regs_o[1], 8'd40);

        // Randomized mix of Wishbone and CPU traffic.
        for (int n = 0; n < 400; n++) begin
            cycle($urandom_range(0, 9) != 0, $urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
                  $urandom_range(0, 23), 8'($urandom), $urandom_range(0, 2) == 0,
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  8'($urandom_range(0, 23)));
        end
        idle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
